// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: MEM-stage load/store request and response bundle
// between the datapath (master) and the data memory (slave).
interface data_memory_ctrl_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Busy;
    logic        AlignError;
    logic        RangeError;
    modport master (
        output Address, WriteData, MemRead, MemWrite, Size, Unsigned,
        input  ReadData, Ready, Busy, AlignError, RangeError
    );
    modport slave (
        input  Address, WriteData, MemRead, MemWrite, Size, Unsigned,
        output ReadData, Ready, Busy, AlignError, RangeError
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: clocked big-endian byte/half/word data memory with
// self-clear after reset, configurable latency and error reporting.
module data_memory_ctrl #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 1
) (
    input  logic              Clock,
    input  logic              ResetN,
    data_memory_ctrl_if.slave bus
);
    localparam int AW = $clog2(WORDS);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_DONE} state_t;
    state_t      r_state, w_next;
    logic [AW-1:0] r_clr;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [1:0]  r_size;
    logic        r_uns, r_wr;
    logic [31:0] r_mem [WORDS];
    logic [AW-1:0] w_idx;
    logic        w_req, w_fire, w_align, w_range, w_ok;
    logic [31:0] w_old, w_bsh, w_hsh, w_mask, w_data, w_load;
    assign w_req   = bus.MemRead || bus.MemWrite;
    assign w_fire  = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_idx   = r_addr[AW+1:2];
    assign w_align = (r_size == 2'b01 && r_addr[0]) || (r_size[1] && r_addr[1:0] != 2'b00);
    assign w_range = {2'b00, r_addr[31:2]} >= 32'(WORDS);
    assign w_ok    = !w_align && !w_range;
    // Big-endian lanes: offset 0 is the most significant byte/half.
    assign w_old   = r_mem[w_idx];
    assign w_bsh   = w_old >> {~r_addr[1:0], 3'b000};
    assign w_hsh   = w_old >> {~r_addr[1], 4'b0000};
    assign w_mask  = r_size == 2'b00 ? 32'h0000_00FF << {~r_addr[1:0], 3'b000} :
                     r_size == 2'b01 ? 32'h0000_FFFF << {~r_addr[1], 4'b0000} : 32'hFFFF_FFFF;
    assign w_data  = r_size == 2'b00 ? {4{r_wdata[7:0]}} :
                     r_size == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;
    assign w_load  = r_size == 2'b00 ? {{24{!r_uns && w_bsh[7]}}, w_bsh[7:0]} :
                     r_size == 2'b01 ? {{16{!r_uns && w_hsh[15]}}, w_hsh[15:0]} : w_old;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT: w_next = (r_clr == AW'(WORDS - 1)) ? S_IDLE : S_INIT;
            S_IDLE: w_next = w_req ? S_WAIT : S_IDLE;
            S_WAIT: w_next = (r_cnt == 4'd0) ? S_DONE : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= S_INIT;
            r_clr   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_INIT) r_clr <= r_clr + 1'b1;
            if (r_state == S_IDLE && w_req) begin
                r_addr  <= bus.Address;
                r_wdata <= bus.WriteData;
                r_size  <= bus.Size;
                r_uns   <= bus.Unsigned;
                r_wr    <= bus.MemWrite;
                r_cnt   <= 4'(LATENCY);
            end
            if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 1'b1;
            if (w_fire && !r_wr && w_ok) r_rdata <= w_load;
        end
    end
    // Array has no reset of its own: INIT sweeps it, and the gated state keeps resets from writing.
    always_ff @(posedge Clock) begin
        if (r_state == S_INIT) r_mem[r_clr] <= '0;
        else if (w_fire && r_wr && w_ok) r_mem[w_idx] <= (w_old & ~w_mask) | (w_data & w_mask);
    end
    assign bus.ReadData   = r_rdata;
    assign bus.Ready      = r_state == S_DONE;
    assign bus.Busy       = r_state != S_IDLE;
    assign bus.AlignError = bus.Ready && w_align;
    assign bus.RangeError = bus.Ready && !w_align && w_range;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed vector table on a WORDS=256/LATENCY=1 memory,
// plus reset, init and throughput sequences on WORDS=4 / LATENCY 3 and 0 copies.
module tb_data_memory_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [2:0]       rd = '0, wr = '0, un = '0;
    logic [2:0][1:0]  sz = '0;
    logic [2:0][31:0] ad = '0, wd = '0;
    logic [2:0][31:0] o_rd;
    logic [2:0]       o_rdy, o_busy, o_al, o_ra;
    for (genvar g = 0; g < 3; g++) begin : gd
        data_memory_ctrl_if bus ();
        assign bus.MemRead   = rd[g];
        assign bus.MemWrite  = wr[g];
        assign bus.Size      = sz[g];
        assign bus.Unsigned  = un[g];
        assign bus.Address   = ad[g];
        assign bus.WriteData = wd[g];
        assign o_rd[g]   = bus.ReadData;
        assign o_rdy[g]  = bus.Ready;
        assign o_busy[g] = bus.Busy;
        assign o_al[g]   = bus.AlignError;
        assign o_ra[g]   = bus.RangeError;
        data_memory_ctrl #(.WORDS(g == 0 ? 256 : 4), .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 0))) dut (
            .Clock(clk), .ResetN(rst_n), .bus(bus)
        );
    end
    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] q;
        logic        al;
        logic        ra;
    } vec_t;
    localparam logic [1:0] R = 2'b10, W = 2'b01, B = 2'b11;
    vec_t tv [27];
    int total = 0, passed = 0;
    logic seen_rdy;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask
    task automatic access(input int s, input logic [1:0] op, input logic [1:0] size, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] q, output logic al, output logic ra);
        int n;
        n = 0;
        while (o_busy[s] && n < 1000) begin @(negedge clk); n++; end
        rd[s] = op[1]; wr[s] = op[0]; sz[s] = size; un[s] = u; ad[s] = a; wd[s] = d;
        @(posedge clk);
        @(negedge clk);
        rd[s] = 1'b0; wr[s] = 1'b0;
        lat = 0;
        while (!o_rdy[s] && lat < 50) begin @(negedge clk); lat++; end
        q = o_rd[s]; al = o_al[s]; ra = o_ra[s];
    endtask
    task automatic wait_init(output int n0, output int n1, output int n2);
        int n;
        n = 0; n0 = -1; n1 = -1; n2 = -1;
        while (n < 600 && (n0 < 0 || n1 < 0 || n2 < 0)) begin
            @(negedge clk);
            n++;
            seen_rdy = seen_rdy | o_rdy[0];
            if (!o_busy[0] && n0 < 0) n0 = n;
            if (!o_busy[1] && n1 < 0) n1 = n;
            if (!o_busy[2] && n2 < 0) n2 = n;
        end
    endtask
    task automatic held(input int s, input int lat_cfg);
        int n, k;
        int p [3];
        n = 0; k = 0; p = '{-100, -100, -100};
        while (o_busy[s] && n < 100) begin @(negedge clk); n++; end
        rd[s] = 1'b1; wr[s] = 1'b0; sz[s] = 2'b10; ad[s] = 32'h4;
        n = 0;
        while (k < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (o_rdy[s]) begin p[k] = n; k++; end
        end
        rd[s] = 1'b0;
        chk($sformatf("held%0d_first", s), 32'(p[0]), 32'(lat_cfg + 2));
        chk($sformatf("held%0d_gap1", s), 32'(p[1] - p[0]), 32'(lat_cfg + 3));
        chk($sformatf("held%0d_gap2", s), 32'(p[2] - p[1]), 32'(lat_cfg + 3));
    endtask
    initial begin
        int lat, n0, n1, n2;
        logic [31:0] q;
        logic al, ra;
        tv[0]  = '{W, 2'd2, 1'b0, 32'h10,  32'h12345678, 32'h00000000, 1'b0, 1'b0};
        tv[1]  = '{R, 2'd2, 1'b0, 32'h10,  32'h0,        32'h12345678, 1'b0, 1'b0};
        tv[2]  = '{W, 2'd0, 1'b0, 32'h11,  32'h000000AB, 32'h12345678, 1'b0, 1'b0};
        tv[3]  = '{R, 2'd2, 1'b0, 32'h10,  32'h0,        32'h12AB5678, 1'b0, 1'b0};
        tv[4]  = '{R, 2'd0, 1'b0, 32'h11,  32'h0,        32'hFFFFFFAB, 1'b0, 1'b0};
        tv[5]  = '{R, 2'd0, 1'b1, 32'h11,  32'h0,        32'h000000AB, 1'b0, 1'b0};
        tv[6]  = '{R, 2'd1, 1'b0, 32'h12,  32'h0,        32'h00005678, 1'b0, 1'b0};
        tv[7]  = '{R, 2'd1, 1'b0, 32'h13,  32'h0,        32'h00005678, 1'b1, 1'b0};
        tv[8]  = '{W, 2'd2, 1'b0, 32'h400, 32'hFFFFFFFF, 32'h00005678, 1'b0, 1'b1};
        tv[9]  = '{W, 2'd2, 1'b0, 32'h02,  32'h11111111, 32'h00005678, 1'b1, 1'b0};
        tv[10] = '{R, 2'd2, 1'b0, 32'h10,  32'h0,        32'h12AB5678, 1'b0, 1'b0};
        tv[11] = '{R, 2'd2, 1'b0, 32'h00,  32'h0,        32'h00000000, 1'b0, 1'b0};
        tv[12] = '{W, 2'd1, 1'b0, 32'h12,  32'h00008001, 32'h00000000, 1'b0, 1'b0};
        tv[13] = '{R, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFF8001, 1'b0, 1'b0};
        tv[14] = '{R, 2'd1, 1'b1, 32'h12,  32'h0,        32'h00008001, 1'b0, 1'b0};
        tv[15] = '{R, 2'd3, 1'b1, 32'h10,  32'h0,        32'h12AB8001, 1'b0, 1'b0};
        tv[16] = '{R, 2'd0, 1'b0, 32'h10,  32'h0,        32'h00000012, 1'b0, 1'b0};
        tv[17] = '{R, 2'd0, 1'b0, 32'h13,  32'h0,        32'h00000001, 1'b0, 1'b0};
        tv[18] = '{R, 2'd1, 1'b0, 32'h10,  32'h0,        32'h000012AB, 1'b0, 1'b0};
        tv[19] = '{B, 2'd2, 1'b0, 32'h14,  32'hCAFEBABE, 32'h000012AB, 1'b0, 1'b0};
        tv[20] = '{R, 2'd2, 1'b0, 32'h14,  32'h0,        32'hCAFEBABE, 1'b0, 1'b0};
        tv[21] = '{R, 2'd2, 1'b0, 32'h400, 32'h0,        32'hCAFEBABE, 1'b0, 1'b1};
        tv[22] = '{R, 2'd1, 1'b0, 32'h11,  32'h0,        32'hCAFEBABE, 1'b1, 1'b0};
        tv[23] = '{W, 2'd0, 1'b0, 32'h14,  32'h00000077, 32'hCAFEBABE, 1'b0, 1'b0};
        tv[24] = '{W, 2'd0, 1'b0, 32'h17,  32'h00000099, 32'hCAFEBABE, 1'b0, 1'b0};
        tv[25] = '{R, 2'd2, 1'b0, 32'h14,  32'h0,        32'h77FEBA99, 1'b0, 1'b0};
        tv[26] = '{R, 2'd2, 1'b0, 32'h401, 32'h0,        32'h77FEBA99, 1'b1, 1'b0};
        seen_rdy = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(o_busy[0]), 32'd1);
        chk("rst_ready", 32'(o_rdy[0]), 32'd0);
        chk("rst_rdata", o_rd[0], 32'd0);
        chk("rst_align", 32'(o_al[0]), 32'd0);
        chk("rst_range", 32'(o_ra[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(n0, n1, n2);
        chk("init_len_256", 32'(n0), 32'd256);
        chk("init_len_4a", 32'(n1), 32'd4);
        chk("init_len_4b", 32'(n2), 32'd4);
        for (int i = 0; i < 27; i++) begin
            access(0, tv[i].op, tv[i].size, tv[i].u, tv[i].a, tv[i].d, lat, q, al, ra);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_rdata", i), q, tv[i].q);
            chk($sformatf("v%0d_align", i), 32'(al), 32'(tv[i].al));
            chk($sformatf("v%0d_range", i), 32'(ra), 32'(tv[i].ra));
        end
        access(0, W, 2'd2, 1'b0, 32'h000, 32'hDEADDEAD, lat, q, al, ra);
        access(0, W, 2'd2, 1'b0, 32'h3FC, 32'hAAAA5555, lat, q, al, ra);
        access(0, R, 2'd2, 1'b0, 32'h3FC, 32'h0, lat, q, al, ra);
        chk("garbage_last", q, 32'hAAAA5555);
        access(0, R, 2'd2, 1'b0, 32'h000, 32'h0, lat, q, al, ra);
        chk("garbage_first", q, 32'hDEADDEAD);
        @(negedge clk);
        wr[0] = 1'b1; sz[0] = 2'd2; ad[0] = 32'h20; wd[0] = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        wr[0] = 1'b0;
        chk("midstore_waiting", 32'(o_busy[0] && !o_rdy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdata", o_rd[0], 32'd0);
        chk("midrst_busy", 32'(o_busy[0]), 32'd1);
        seen_rdy = 1'b0;
        repeat (3) begin @(negedge clk); seen_rdy = seen_rdy | o_rdy[0]; end
        rst_n = 1'b1;
        wait_init(n0, n1, n2);
        chk("midrst_no_ready", 32'(seen_rdy), 32'd0);
        chk("reinit_len", 32'(n0), 32'd256);
        access(0, R, 2'd2, 1'b0, 32'h20, 32'h0, lat, q, al, ra);
        chk("dropped_store", q, 32'd0);
        access(0, R, 2'd2, 1'b0, 32'h000, 32'h0, lat, q, al, ra);
        chk("clear_first", q, 32'd0);
        access(0, R, 2'd2, 1'b0, 32'h3FC, 32'h0, lat, q, al, ra);
        chk("clear_last", q, 32'd0);
        chk("clear_last_flags", 32'({al, ra}), 32'd0);
        access(1, W, 2'd2, 1'b0, 32'h4, 32'h01020304, lat, q, al, ra);
        chk("w4l3_sw_latency", 32'(lat), 32'd4);
        access(1, R, 2'd2, 1'b0, 32'h4, 32'h0, lat, q, al, ra);
        chk("w4l3_lw_latency", 32'(lat), 32'd4);
        chk("w4l3_lw_rdata", q, 32'h01020304);
        access(1, R, 2'd0, 1'b0, 32'h7, 32'h0, lat, q, al, ra);
        chk("w4l3_lb_rdata", q, 32'h00000004);
        access(1, R, 2'd2, 1'b0, 32'h10, 32'h0, lat, q, al, ra);
        chk("w4l3_range", 32'({al, ra}), 32'b01);
        chk("w4l3_range_rdata", q, 32'h00000004);
        access(1, R, 2'd2, 1'b0, 32'hC, 32'h0, lat, q, al, ra);
        chk("w4l3_lastword", {q[31:1], ra}, 32'd0);
        held(1, 3);
        access(2, W, 2'd2, 1'b0, 32'hC, 32'h80000000, lat, q, al, ra);
        chk("w4l0_sw_latency", 32'(lat), 32'd1);
        access(2, R, 2'd1, 1'b0, 32'hC, 32'h0, lat, q, al, ra);
        chk("w4l0_lh_latency", 32'(lat), 32'd1);
        chk("w4l0_lh_rdata", q, 32'hFFFF8000);
        access(2, R, 2'd2, 1'b0, 32'h10, 32'h0, lat, q, al, ra);
        chk("w4l0_range", 32'({al, ra}), 32'b01);
        held(2, 0);
        held(0, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
